// File: rtl/tempn_pkg.sv
// Shared TempN scratch-memory definitions, used by both the reader and writer sides.
package tempn_pkg;

  localparam int TEMPN_DATA_W = 26;
  localparam int TEMPN_ADDR_W = 11;

  typedef logic [TEMPN_ADDR_W-1:0] tempn_addr_t;
  typedef logic [TEMPN_DATA_W-1:0] tempn_word_t;

  typedef enum logic [1:0] {
    TEMPN_IDLE  = 2'd0,
    TEMPN_RUN   = 2'd1,
    TEMPN_FLUSH = 2'd2
  } tempn_state_e;

endpackage

// File: rtl/tempn_stream_reader.sv
// TempN read sequencer: walks a (base, count, stride) window over the scratch memory
// and streams each word out on a registered valid/ready interface with last/busy/done.
module tempn_stream_reader
  import tempn_pkg::*;
#(
  parameter int DATA_W = TEMPN_DATA_W,
  parameter int ADDR_W = TEMPN_ADDR_W,
  parameter int CNT_W  = ADDR_W + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic [ADDR_W-1:0] cfg_base,
  input  logic [CNT_W-1:0]  cfg_count,
  input  logic [ADDR_W-1:0] cfg_stride,
  output logic [ADDR_W-1:0] mem_raddr,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  output logic              out_last,
  input  logic              out_ready,
  output logic              busy,
  output logic              done
);

  localparam logic [1:0] S_IDLE  = TEMPN_IDLE;
  localparam logic [1:0] S_RUN   = TEMPN_RUN;
  localparam logic [1:0] S_FLUSH = TEMPN_FLUSH;

  logic [1:0]        r_state;
  logic [ADDR_W-1:0] r_addr;
  logic [ADDR_W-1:0] r_stride;
  logic [CNT_W-1:0]  r_remaining;
  logic [DATA_W-1:0] r_data;
  logic              r_valid;
  logic              r_last;
  logic              r_busy;
  logic              r_done;

  logic              w_accept;
  logic              w_load;
  logic              w_final;

  assign w_accept = r_valid && out_ready;
  // The output register refills whenever it is empty or being drained this cycle.
  assign w_load   = (r_state == S_RUN) && (r_remaining != '0) && (!r_valid || out_ready);
  assign w_final  = (r_remaining == CNT_W'(1));

  // NOTE: all state below is sequential, so every assignment is non-blocking; blocking
  // assignments here would make downstream reads in the same block see next-cycle values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_addr      <= '0;
      r_stride    <= '0;
      r_remaining <= '0;
      r_data      <= '0;
      r_valid     <= 1'b0;
      r_last      <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (abort) begin
        r_state     <= S_IDLE;
        r_remaining <= '0;
        r_valid     <= 1'b0;
        r_last      <= 1'b0;
        r_busy      <= 1'b0;
      end else begin
        case (r_state)
          S_IDLE: begin
            r_busy <= start;
            if (start) begin
              r_addr      <= cfg_base;
              r_stride    <= cfg_stride;
              r_remaining <= cfg_count;
              // An empty window completes immediately without leaving IDLE.
              if (cfg_count == '0) r_done  <= 1'b1;
              else                 r_state <= S_RUN;
            end
          end
          S_RUN: begin
            if (w_load) begin
              r_data      <= mem_rdata;
              r_valid     <= 1'b1;
              r_last      <= w_final;
              r_addr      <= r_addr + r_stride;
              r_remaining <= r_remaining - CNT_W'(1);
              if (w_final) r_state <= S_FLUSH;
            end else if (w_accept) begin
              r_valid <= 1'b0;
            end
          end
          S_FLUSH: begin
            if (w_accept) begin
              r_valid <= 1'b0;
              r_last  <= 1'b0;
              r_done  <= 1'b1;
              r_busy  <= 1'b0;
              r_state <= S_IDLE;
            end
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  assign mem_raddr = r_addr;
  assign out_data  = r_data;
  assign out_valid = r_valid;
  assign out_last  = r_last;
  assign busy      = r_busy;
  assign done      = r_done;

endmodule

// File: tb/tb_tempn_stream_reader.sv
// Directed bench for tempn_stream_reader: windowed reads against a model of mem[i]=i*3.
module tb_tempn_stream_reader;
  import tempn_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        abort;
  logic [10:0] cfg_base;
  logic [11:0] cfg_count;
  logic [10:0] cfg_stride;
  logic [10:0] mem_raddr;
  logic [25:0] mem_rdata;
  logic [25:0] out_data;
  logic        out_valid;
  logic        out_last;
  logic        out_ready;
  logic        busy;
  logic        done;

  tempn_word_t mem [0:2047];

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [10:0] base;
    logic [11:0] count;
    logic [10:0] stride;
    bit          stall;     // out_ready follows 1,0,0,1,0,0,...
    bit          poke;      // pulse start with other cfg mid-run
    logic [25:0] exp_first;
    logic [25:0] exp_final;
  } vec_t;

  vec_t vecs [5];

  tempn_stream_reader dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .abort      (abort),
    .cfg_base   (cfg_base),
    .cfg_count  (cfg_count),
    .cfg_stride (cfg_stride),
    .mem_raddr  (mem_raddr),
    .mem_rdata  (mem_rdata),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_last   (out_last),
    .out_ready  (out_ready),
    .busy       (busy),
    .done       (done)
  );

  assign mem_rdata = mem[mem_raddr];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic run_window(input vec_t v, input int idx);
    logic [10:0] a;
    logic [25:0] prev_data;
    logic [25:0] first_d;
    logic [25:0] final_d;
    logic        prev_last;
    logic        prev_hold;
    int          beats;
    int          cyc;
    @(negedge clk);
    cfg_base   = v.base;
    cfg_count  = v.count;
    cfg_stride = v.stride;
    start      = 1'b1;
    out_ready  = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check($sformatf("v%0d busy after start", idx), 32'(busy), 32'd1);
    check($sformatf("v%0d no valid yet", idx), 32'(out_valid), 32'd0);
    @(negedge clk);
    a = v.base; beats = 0; cyc = 0; prev_hold = 1'b0;
    prev_data = '0; prev_last = 1'b0; first_d = '0; final_d = '0;
    while (beats < int'(v.count) && cyc < 4 * int'(v.count) + 20) begin
      out_ready = v.stall ? (cyc % 3 == 0) : 1'b1;
      start     = v.poke && (cyc == 2);
      if (start) begin
        cfg_base = 11'd0; cfg_count = 12'd2; cfg_stride = 11'd7;
      end
      if (!v.stall) check($sformatf("v%0d no bubble c%0d", idx, cyc), 32'(out_valid), 32'd1);
      if (prev_hold) begin
        check($sformatf("v%0d hold valid c%0d", idx, cyc), 32'(out_valid), 32'd1);
        check($sformatf("v%0d hold data c%0d", idx, cyc), 32'(out_data), 32'(prev_data));
        check($sformatf("v%0d hold last c%0d", idx, cyc), 32'(out_last), 32'(prev_last));
      end
      if (out_valid && out_ready) begin
        check($sformatf("v%0d data b%0d", idx, beats), 32'(out_data), 32'(a) * 32'd3);
        check($sformatf("v%0d last b%0d", idx, beats), 32'(out_last),
              32'(beats == int'(v.count) - 1));
        if (beats == 0) first_d = out_data;
        final_d = out_data;
        a = a + v.stride;
        beats++;
      end
      prev_hold = out_valid && !out_ready;
      prev_data = out_data;
      prev_last = out_last;
      @(negedge clk);
      cyc++;
    end
    start     = 1'b0;
    out_ready = 1'b1;
    check($sformatf("v%0d beat count", idx), 32'(beats), 32'(v.count));
    check($sformatf("v%0d first word", idx), 32'(first_d), 32'(v.exp_first));
    check($sformatf("v%0d final word", idx), 32'(final_d), 32'(v.exp_final));
    check($sformatf("v%0d done pulse", idx), 32'(done), 32'd1);
    check($sformatf("v%0d valid clear", idx), 32'(out_valid), 32'd0);
    check($sformatf("v%0d busy clear", idx), 32'(busy), 32'd0);
    @(negedge clk);
    check($sformatf("v%0d done one cycle", idx), 32'(done), 32'd0);
  endtask

  initial begin
    int n;
    for (int i = 0; i < 2048; i++) mem[i] = tempn_word_t'(i * 3);

    //           base     count    stride  stall poke first     final
    vecs[0] = '{11'd0,    12'd761, 11'd1,  1'b0, 1'b0, 26'd0,    26'd2280};
    vecs[1] = '{11'd2045, 12'd5,   11'd1,  1'b0, 1'b0, 26'd6135, 26'd3};
    vecs[2] = '{11'd10,   12'd4,   11'd2,  1'b1, 1'b0, 26'd30,   26'd48};
    vecs[3] = '{11'd200,  12'd6,   11'd1,  1'b0, 1'b1, 26'd600,  26'd615};
    vecs[4] = '{11'd2040, 12'd3,   11'd5,  1'b1, 1'b1, 26'd6120, 26'd6};

    rst_n = 1'b0; start = 1'b0; abort = 1'b0; out_ready = 1'b0;
    cfg_base = '0; cfg_count = '0; cfg_stride = '0;
    repeat (2) @(negedge clk);
    check("reset raddr", 32'(mem_raddr), 32'd0);
    check("reset data", 32'(out_data), 32'd0);
    check("reset valid", 32'(out_valid), 32'd0);
    check("reset last", 32'(out_last), 32'd0);
    check("reset busy", 32'(busy), 32'd0);
    check("reset done", 32'(done), 32'd0);
    rst_n = 1'b1;

    for (int i = 0; i < 5; i++) run_window(vecs[i], i);

    // Empty window: done and a single busy cycle, no data.
    @(negedge clk);
    cfg_base = 11'd7; cfg_count = 12'd0; cfg_stride = 11'd1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("zero done", 32'(done), 32'd1);
    check("zero busy", 32'(busy), 32'd1);
    check("zero valid", 32'(out_valid), 32'd0);
    @(negedge clk);
    check("zero done drop", 32'(done), 32'd0);
    check("zero busy drop", 32'(busy), 32'd0);
    check("zero valid after", 32'(out_valid), 32'd0);

    // Abort with a stalled word in flight after three accepted beats.
    cfg_base = 11'd100; cfg_count = 12'd10; cfg_stride = 11'd1; start = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    for (int c = 0; c < 20 && n < 3; c++) begin
      @(negedge clk);
      if (out_valid && out_ready) n++;
    end
    check("abort accepted beats", 32'(n), 32'd3);
    @(negedge clk);
    out_ready = 1'b0;
    check("abort pre valid", 32'(out_valid), 32'd1);
    check("abort pre data", 32'(out_data), 32'd309);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("abort valid", 32'(out_valid), 32'd0);
    check("abort last", 32'(out_last), 32'd0);
    check("abort busy", 32'(busy), 32'd0);
    check("abort done", 32'(done), 32'd0);
    @(negedge clk);
    check("abort no late done", 32'(done), 32'd0);
    check("abort stays idle", 32'(out_valid), 32'd0);
    out_ready = 1'b1;

    run_window('{11'd500, 12'd3, 11'd3, 1'b0, 1'b0, 26'd1500, 26'd1518}, 5);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
